data_mem_buf: RTL and testbench

Parametrised successor to the input data memory: a multi-read-port feature buffer for the Winograd datapath.
- Adds a self-addressing scan loader FSM: base address, length, auto-increment, wrap and done pulse.
- Adds per-port valid/ready read handshakes with a configurable registered read latency and out-of-range detection.
- Sits between the testbench/scan interface and the tile controllers; each controller owns one read port.

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_mem_array.sv | 42 ++++
 rtl/data_mem_buf.sv | 175 +++++++++++++++++
 tb/tb_data_mem_buf.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the Winograd feature buffer.
// Holds the scan FSM state type, default sizes and the address wrap rule.
package data_mem_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int DEPTH_DEF  = 128;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } scan_state_t;

    function automatic int next_addr(input int addr, input int depth);
        return (addr == depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Feature storage: one synchronous write port, NUM_RD synchronous read ports.
// Ports: clk, we/waddr/wdata (write), re/raddr (per-port read), rdata (registered).
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q [NUM_RD];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read registers only update on an enabled read, so they hold otherwise.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (re[i]) begin
                rd_q[i] <= mem[raddr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign rdata[g*DATA_W +: DATA_W] = rd_q[g];
    end

endmodule

// File: rtl/data_mem_buf.sv
// Multi-read-port feature buffer with a self-addressing scan loader.
// Ports: scan_* load burst interface, rd_* per-port valid/ready read ports.
module data_mem_buf
    import data_mem_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scan_start,
    input  logic [ADDR_W-1:0]        scan_base,
    input  logic [ADDR_W:0]          scan_len,
    input  logic                     scan_valid,
    input  logic [DATA_W-1:0]        scan_in,
    output logic                     scan_busy,
    output logic                     scan_done,
    input  logic [NUM_RD-1:0]        rd_valid_in,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_in,
    output logic                     rd_ready_out,
    output logic [NUM_RD-1:0]        rd_valid_out,
    output logic [NUM_RD*DATA_W-1:0] rd_data_out,
    output logic [NUM_RD*ADDR_W-1:0] rd_addr_out,
    output logic [NUM_RD-1:0]        rd_err_out
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    scan_state_t       state, state_n;
    logic [ADDR_W-1:0] waddr, waddr_n;
    logic [ADDR_W:0]   remaining, remaining_n;
    logic              we;

    always_comb begin
        state_n     = state;
        waddr_n     = waddr;
        remaining_n = remaining;
        we          = 1'b0;
        unique case (state)
            IDLE: begin
                if (scan_start) begin
                    waddr_n     = ({1'b0, scan_base} < DEPTH_L) ? scan_base : '0;
                    remaining_n = scan_len;
                    state_n     = (scan_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (scan_valid) begin
                    we          = 1'b1;
                    remaining_n = remaining - ONE_L;
                    waddr_n     = ADDR_W'(next_addr(int'(waddr), DEPTH));
                    if (remaining == ONE_L) begin
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            waddr     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_n;
            waddr     <= waddr_n;
            remaining <= remaining_n;
        end
    end

    assign scan_busy    = (state == LOAD);
    assign scan_done    = (state == DONE);
    assign rd_ready_out = (state == IDLE);

    logic [NUM_RD-1:0]        acc, in_rng, re;
    logic [NUM_RD*DATA_W-1:0] arr_rdata;

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            acc[i]    = rd_valid_in[i] & rd_ready_out;
            in_rng[i] = {1'b0, rd_addr_in[i*ADDR_W +: ADDR_W]} < DEPTH_L;
        end
        re = acc & in_rng;
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (scan_in),
        .re    (re),
        .raddr (rd_addr_in),
        .rdata (arr_rdata)
    );

    // sel1 marks that the array register holds the live result; it is
    // cleared by reset and by out-of-range reads so those show zero data.
    logic [NUM_RD-1:0]        v1, sel1, err1;
    logic [NUM_RD*ADDR_W-1:0] a1;
    logic [NUM_RD*DATA_W-1:0] d1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1   <= '0;
            sel1 <= '0;
            err1 <= '0;
            a1   <= '0;
        end else begin
            v1 <= acc;
            for (int i = 0; i < NUM_RD; i++) begin
                if (acc[i]) begin
                    sel1[i]                <= in_rng[i];
                    err1[i]                <= ~in_rng[i];
                    a1[i*ADDR_W +: ADDR_W] <= rd_addr_in[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    always_comb begin
        d1 = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (sel1[i]) begin
                d1[i*DATA_W +: DATA_W] = arr_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    if (READ_LAT >= 2) begin : g_lat2
        logic [NUM_RD-1:0]        v2, err2;
        logic [NUM_RD*ADDR_W-1:0] a2;
        logic [NUM_RD*DATA_W-1:0] d2;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v2   <= '0;
                err2 <= '0;
                a2   <= '0;
                d2   <= '0;
            end else begin
                v2 <= v1;
                for (int i = 0; i < NUM_RD; i++) begin
                    if (v1[i]) begin
                        err2[i]                <= err1[i];
                        a2[i*ADDR_W +: ADDR_W] <= a1[i*ADDR_W +: ADDR_W];
                        d2[i*DATA_W +: DATA_W] <= d1[i*DATA_W +: DATA_W];
                    end
                end
            end
        end

        assign rd_valid_out = v2;
        assign rd_err_out   = err2;
        assign rd_addr_out  = a2;
        assign rd_data_out  = d2;
    end else begin : g_lat1
        assign rd_valid_out = v1;
        assign rd_err_out   = err1;
        assign rd_addr_out  = a1;
        assign rd_data_out  = d1;
    end

endmodule

// File: tb/tb_data_mem_buf.sv
// Randomized self-checking bench for data_mem_buf, READ_LAT 1 and 2 side by side.
// A queue-free slot model predicts every read result and scan status cycle by cycle.
module tb_data_mem_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 200;
    localparam int AW    = 8;
    localparam int NR    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          scan_start = 1'b0;
    logic [AW-1:0] scan_base = '0;
    logic [AW:0]   scan_len = '0;
    logic          scan_valid = 1'b0;
    logic [DW-1:0] scan_in = '0;
    logic [NR-1:0] rd_valid_in = '0;
    logic [NR*AW-1:0] rd_addr_in = '0;

    logic             busy1, done1, rdy1, busy2, done2, rdy2;
    logic [NR-1:0]    vo1, eo1, vo2, eo2;
    logic [NR*DW-1:0] do1, do2;
    logic [NR*AW-1:0] ao1, ao2;

    always #5 clk = ~clk;

    data_mem_buf #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .READ_LAT(1)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_valid(scan_valid), .scan_in(scan_in),
        .scan_busy(busy1), .scan_done(done1),
        .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in),
        .rd_ready_out(rdy1), .rd_valid_out(vo1), .rd_data_out(do1),
        .rd_addr_out(ao1), .rd_err_out(eo1)
    );

    data_mem_buf #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .READ_LAT(2)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_valid(scan_valid), .scan_in(scan_in),
        .scan_busy(busy2), .scan_done(done2),
        .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in),
        .rd_ready_out(rdy2), .rd_valid_out(vo2), .rd_data_out(do2),
        .rd_addr_out(ao2), .rd_err_out(eo2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ms 0=idle 1=loading 2=done-pulse.
    int            ms = 0;
    int            m_wa = 0;
    int            m_rem = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [DEPTH];

    // Result slots indexed [latency-1][port][due cycle mod 4].
    bit            rv   [2][NR][4];
    logic [DW-1:0] rdat [2][NR][4];
    logic [AW-1:0] radr [2][NR][4];
    bit            rerr [2][NR][4];

    bit            ev [2][NR];
    logic [DW-1:0] ed [2][NR];
    logic [AW-1:0] ea [2][NR];
    bit            ee [2][NR];

    task automatic clear_model();
        ms = 0;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < NR; p++) begin
                ev[l][p] = 1'b0;
                ed[l][p] = '0;
                ea[l][p] = '0;
                ee[l][p] = 1'b0;
                for (int s = 0; s < 4; s++) rv[l][p][s] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy1", busy1, ms == 1);
        chk("done1", done1, ms == 2);
        chk("busy2", busy2, ms == 1);
        chk("done2", done2, ms == 2);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("L1_p%0d_valid", p), vo1[p], ev[0][p]);
            chk($sformatf("L1_p%0d_data", p), do1[p*DW +: DW], ed[0][p]);
            chk($sformatf("L1_p%0d_addr", p), ao1[p*AW +: AW], ea[0][p]);
            chk($sformatf("L1_p%0d_err", p), eo1[p], ee[0][p]);
            chk($sformatf("L2_p%0d_valid", p), vo2[p], ev[1][p]);
            chk($sformatf("L2_p%0d_data", p), do2[p*DW +: DW], ed[1][p]);
            chk($sformatf("L2_p%0d_addr", p), ao2[p*AW +: AW], ea[1][p]);
            chk($sformatf("L2_p%0d_err", p), eo2[p], ee[1][p]);
        end
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        int a;
        int s;
        chk("ready1", rdy1, ms == 0);
        chk("ready2", rdy2, ms == 0);
        for (int p = 0; p < NR; p++) begin
            if (rd_valid_in[p] && ms == 0) begin
                a = int'(rd_addr_in[p*AW +: AW]);
                for (int l = 0; l < 2; l++) begin
                    s = (cyc + l) % 4;
                    rv[l][p][s]   = 1'b1;
                    radr[l][p][s] = AW'(a);
                    rerr[l][p][s] = (a >= DEPTH);
                    rdat[l][p][s] = (a >= DEPTH) ? '0 : ref_mem[a];
                end
            end
        end
        case (ms)
            0: if (scan_start) begin
                m_wa  = (int'(scan_base) >= DEPTH) ? 0 : int'(scan_base);
                m_rem = int'(scan_len);
                ms    = (m_rem == 0) ? 2 : 1;
            end
            1: if (scan_valid) begin
                ref_mem[m_wa] = scan_in;
                m_wa  = (m_wa + 1) % DEPTH;
                m_rem = m_rem - 1;
                if (m_rem == 0) ms = 2;
            end
            default: ms = 0;
        endcase
        s = cyc % 4;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < NR; p++) begin
                ev[l][p] = rv[l][p][s];
                if (rv[l][p][s]) begin
                    ed[l][p] = rdat[l][p][s];
                    ea[l][p] = radr[l][p][s];
                    ee[l][p] = rerr[l][p][s];
                end
                rv[l][p][s] = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rd2(input bit v0, input int a0, input bit v1, input int a1);
        rd_valid_in = {v1, v0};
        rd_addr_in  = {AW'(a1), AW'(a0)};
        step();
    endtask

    task automatic idle(input int n);
        rd_valid_in = '0;
        scan_start  = 1'b0;
        scan_valid  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // mode 0: valid every cycle, 1: toggling 1,0,1.., 2: random.
    task automatic load_burst(input int base, input int len, input int mode,
                              input logic [DW-1:0] dbase);
        int n = 0;
        int k = 0;
        scan_start  = 1'b1;
        scan_base   = AW'(base);
        scan_len    = (AW+1)'(len);
        scan_valid  = 1'b0;
        rd_valid_in = '0;
        step();
        while (ms == 1 && k < 4 * len + 20) begin
            scan_valid  = (mode == 0) ? 1'b1 :
                          (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
            scan_in     = (mode == 2) ? DW'($urandom) : dbase + DW'(n);
            scan_start  = 1'($urandom_range(0, 1));
            rd_valid_in = (mode == 1) ? '1 : NR'($urandom_range(0, 3));
            rd_addr_in  = (NR*AW)'($urandom);
            if (scan_valid) n++;
            step();
            k++;
        end
        if (ms == 1) chk("load_timeout", 64'(ms), 64'd0);
        scan_valid  = 1'b0;
        rd_valid_in = '1;
        if (ms == 2) begin
            scan_start = 1'b1;
            scan_base  = 8'd50;
            scan_len   = 9'd3;
            step();
        end
        scan_start  = 1'b0;
        rd_valid_in = '0;
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_done1", done1, 1'b0);
        chk("rst_busy2", busy2, 1'b0);
        chk("rst_done2", done2, 1'b0);
        chk("rst_valid", {vo2, vo1}, '0);
        chk("rst_err", {eo2, eo1}, '0);
        chk("rst_data", {do2, do1}, '0);
        chk("rst_addr", {ao2, ao1}, '0);
        clear_model();
        scan_start  = 1'b0;
        scan_valid  = 1'b0;
        rd_valid_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", {done2, done1}, '0);
        end
        reset = 1'b1;
    endtask

    initial begin
        clear_model();
        async_reset();
        idle(1);

        // Basic burst and back-to-back reads on port 0.
        load_burst(0, 4, 0, 32'hA0);
        for (int i = 0; i < 4; i++) rd2(1, i, 0, 0);
        idle(3);

        // Wrap past the last word.
        load_burst(198, 4, 0, 32'h1100);
        rd2(1, 198, 1, 199);
        rd2(1, 0, 1, 1);
        idle(3);

        // Stalled burst with requests held during load.
        load_burst(20, 3, 1, 32'h2200);
        for (int i = 0; i < 3; i++) rd2(1, 20 + i, 1, 22 - i);
        idle(3);

        // Clamped base, zero-length burst, full-depth burst.
        load_burst(250, 2, 0, 32'h3300);
        rd2(1, 0, 1, 1);
        idle(2);
        load_burst(7, 0, 0, 32'h0);
        idle(1);
        load_burst(0, DEPTH, 2, 32'h0);
        idle(1);

        // Same address on both ports, then out of range.
        rd2(1, 5, 1, 5);
        rd2(0, 0, 1, 200);
        rd2(1, 255, 1, 199);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                load_burst($urandom_range(0, 255), $urandom_range(0, 8), 2, 32'h0);
            end else begin
                rd2(1'($urandom_range(0, 1)), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), $urandom_range(0, 255));
            end
        end
        idle(3);

        // Abort a burst after two of five writes.
        scan_start = 1'b1;
        scan_base  = 8'd10;
        scan_len   = 9'd5;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            scan_valid = 1'b1;
            scan_in    = 32'h5A5A0000 + DW'(i);
            step();
        end
        rd_valid_in = '1;
        async_reset();
        idle(2);
        rd2(1, 10, 1, 11);
        rd2(1, 11, 0, 0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
